// File: rtl/prog_loader_uart.sv
// UART (8N1) program loader: receives a SYNC/ADDR/LEN/DATA/SUM frame, writes the
// payload into CPU instruction memory and releases the CPU reset on a good checksum.
module prog_loader_uart #(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [6:0] inst_address,
  output logic [7:0] inst_data,
  output logic       inst_we,
  output logic       cpu_rst_n,
  output logic       busy,
  output logic       error
);

  localparam int            CW        = 10;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {B_WAIT_SYNC, B_ADDR, B_LEN, B_DATA, B_SUM} byte_state_e;

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_bad_q, frame_bad_d;

  byte_state_e   b_state_q, b_state_d;
  logic [6:0]    ptr_q, ptr_d;
  logic [7:0]    count_q, count_d;
  logic [7:0]    sum_q, sum_d;
  logic [6:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          we_q, we_d;
  logic          cpu_rst_n_q, cpu_rst_n_d;
  logic          busy_q, busy_d;
  logic          error_q, error_d;
  logic          release_q, release_d;
  logic          fail_s;

  // rx is asynchronous: two-stage synchroniser plus one delayed copy for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Bit receiver state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q   <= RX_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_bad_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_bad_q  <= frame_bad_d;
    end
  end

  // Bit receiver next state: mid-bit sampling, LSB first
  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_bad_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          // A start bit that has gone high again by mid-bit is a glitch
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d      = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
          end else begin
            frame_bad_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        cnt_d      = '0;
      end
    endcase
  end

  // Byte FSM and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_state_q   <= B_WAIT_SYNC;
      ptr_q       <= 7'd0;
      count_q     <= 8'd0;
      sum_q       <= 8'h00;
      addr_q      <= 7'd0;
      data_q      <= 8'h00;
      we_q        <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      b_state_q   <= b_state_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      we_q        <= we_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
      release_q   <= release_d;
    end
  end

  // Byte FSM next state: frame parsing, checksum and error handling
  always_comb begin
    b_state_d   = b_state_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    sum_d       = sum_q;
    addr_d      = addr_q;
    data_d      = data_q;
    we_d        = 1'b0;
    busy_d      = busy_q;
    error_d     = error_q;
    release_d   = 1'b0;
    // CPU reset is released the cycle after busy drops on a good checksum
    cpu_rst_n_d = cpu_rst_n_q | release_q;
    fail_s      = 1'b0;
    if (byte_valid_q) begin
      case (b_state_q)
        B_WAIT_SYNC: begin
          if (shift_q == SYNC_BYTE) begin
            busy_d      = 1'b1;
            error_d     = 1'b0;
            cpu_rst_n_d = 1'b0;
            sum_d       = 8'h00;
            b_state_d   = B_ADDR;
          end else begin
            b_state_d = B_WAIT_SYNC;
          end
        end
        B_ADDR: begin
          if (shift_q[7]) begin
            fail_s = 1'b1;
          end else begin
            ptr_d     = shift_q[6:0];
            sum_d     = sum_q ^ shift_q;
            b_state_d = B_LEN;
          end
        end
        B_LEN: begin
          if ((shift_q == 8'd0) || (shift_q > 8'd128)) begin
            fail_s = 1'b1;
          end else begin
            count_d   = shift_q;
            sum_d     = sum_q ^ shift_q;
            b_state_d = B_DATA;
          end
        end
        B_DATA: begin
          we_d    = 1'b1;
          data_d  = shift_q;
          addr_d  = ptr_q;
          ptr_d   = ptr_q + 7'd1;
          sum_d   = sum_q ^ shift_q;
          count_d = count_q - 8'd1;
          if (count_q == 8'd1) begin
            b_state_d = B_SUM;
          end else begin
            b_state_d = B_DATA;
          end
        end
        B_SUM: begin
          if (shift_q == sum_q) begin
            busy_d    = 1'b0;
            release_d = 1'b1;
            b_state_d = B_WAIT_SYNC;
          end else begin
            fail_s = 1'b1;
          end
        end
        default: begin
          b_state_d = B_WAIT_SYNC;
        end
      endcase
    end else if (frame_bad_q && (b_state_q != B_WAIT_SYNC)) begin
      fail_s = 1'b1;
    end else begin
      fail_s = 1'b0;
    end
    if (fail_s) begin
      error_d     = 1'b1;
      busy_d      = 1'b0;
      cpu_rst_n_d = 1'b0;
      b_state_d   = B_WAIT_SYNC;
    end else begin
      error_d = error_d;
    end
  end

  assign inst_address = addr_q;
  assign inst_data    = data_q;
  assign inst_we      = we_q;
  assign cpu_rst_n    = cpu_rst_n_q;
  assign busy         = busy_q;
  assign error        = error_q;

endmodule

// File: tb/tb_prog_loader_uart.sv
// Scoreboard bench for prog_loader_uart: stimulus pushes expected writes, a
// monitor pops and compares them on every inst_we strobe.
module tb_prog_loader_uart;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [6:0] inst_address;
  logic [7:0] inst_data;
  logic       inst_we;
  logic       cpu_rst_n;
  logic       busy;
  logic       error;

  logic [14:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int fall_cyc = -1;
  int rise_cyc = -1;
  logic busy_p = 1'b0;
  logic cpu_p = 1'b0;

  prog_loader_uart #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .inst_address(inst_address), .inst_data(inst_data), .inst_we(inst_we),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records when busy falls and cpu_rst_n rises, for the release-lag check
  always @(negedge clk) begin
    busy_p <= busy;
    cpu_p  <= cpu_rst_n;
    if (busy_p && !busy) fall_cyc <= cyc;
    if (!cpu_p && cpu_rst_n) rise_cyc <= cyc;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n === 1'b1 && inst_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", inst_address, inst_data);
      end else begin
        chk("write_addr_data", {inst_address, inst_data}, {17'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop_bit;
    idle(CPB);
    rx = 1'b1;
    idle(2 * CPB);
  endtask

  task automatic glitch();
    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    idle(3 * CPB);
  endtask

  function automatic logic [7:0] xsum3(input logic [6:0] a, input logic [7:0] d0,
                                       input logic [7:0] d1, input logic [7:0] d2);
    return {1'b0, a} ^ 8'h03 ^ d0 ^ d1 ^ d2;
  endfunction

  task automatic frame3(input logic [6:0] a, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] sb, input bit good);
    logic [6:0] p;
    int t0;
    t0 = cyc;
    p = a;
    exp_q.push_back({p, d0});
    p = p + 7'd1;
    exp_q.push_back({p, d1});
    p = p + 7'd1;
    exp_q.push_back({p, d2});
    send_byte(8'hA5, 1'b1);
    chk("sync_busy", busy, 1);
    chk("sync_err_clear", error, 0);
    chk("sync_cpu_held", cpu_rst_n, 0);
    send_byte({1'b0, a}, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(d0, 1'b1);
    send_byte(d1, 1'b1);
    send_byte(d2, 1'b1);
    send_byte(sb, 1'b1);
    chk("writes_done", exp_q.size(), 0);
    chk("busy_end", busy, 0);
    if (good) begin
      chk("error_good", error, 0);
      chk("cpu_released", cpu_rst_n, 1);
      chk("release_lag", rise_cyc - fall_cyc, 1);
      chk("release_fresh", rise_cyc > t0, 1);
    end else begin
      chk("error_bad_sum", error, 1);
      chk("cpu_held_bad_sum", cpu_rst_n, 0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_addr"}, inst_address, 0);
    chk({tag, "_data"}, inst_data, 0);
    chk({tag, "_we"}, inst_we, 0);
    chk({tag, "_cpu_rst_n"}, cpu_rst_n, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    idle(4);
    check_reset_values("reset");
    rst_n = 1'b1;
    idle(4);

    // Garbage before sync is ignored
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    chk("garbage_busy", busy, 0);
    chk("garbage_error", error, 0);

    // Baseline and address wrap
    frame3(7'h10, 8'h11, 8'h22, 8'h33, 8'h13, 1'b1);
    frame3(7'h7E, 8'hAA, 8'hBB, 8'hCC, xsum3(7'h7E, 8'hAA, 8'hBB, 8'hCC), 1'b1);

    // Bad checksum then recovery
    frame3(7'h10, 8'h11, 8'h22, 8'h33, 8'h14, 1'b0);
    frame3(7'h10, 8'h11, 8'h22, 8'h33, 8'h13, 1'b1);

    // Illegal address byte
    send_byte(8'hA5, 1'b1);
    send_byte(8'h80, 1'b1);
    chk("addr_err", error, 1);
    chk("addr_err_busy", busy, 0);
    chk("addr_err_cpu", cpu_rst_n, 0);

    // Illegal lengths 0 and 129
    send_byte(8'hA5, 1'b1);
    chk("len_sync_clears_err", error, 0);
    send_byte(8'h00, 1'b1);
    chk("len0_pending", busy, 1);
    send_byte(8'h00, 1'b1);
    chk("len0_err", error, 1);
    chk("len0_busy", busy, 0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h81, 1'b1);
    chk("len129_err", error, 1);

    // Glitches on idle line, including between frame bytes
    glitch();
    chk("glitch_busy", busy, 0);
    chk("glitch_error", error, 1);
    exp_q.push_back({7'h20, 8'h01});
    exp_q.push_back({7'h21, 8'h02});
    exp_q.push_back({7'h22, 8'h03});
    send_byte(8'hA5, 1'b1);
    glitch();
    send_byte(8'h20, 1'b1);
    glitch();
    send_byte(8'h03, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(xsum3(7'h20, 8'h01, 8'h02, 8'h03), 1'b1);
    chk("glitch_frame_writes", exp_q.size(), 0);
    chk("glitch_frame_ok", {busy, error, cpu_rst_n}, 3'b001);

    // Framing error inside DATA aborts the frame; trailing byte is ignored
    exp_q.push_back({7'h10, 8'h11});
    send_byte(8'hA5, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    chk("framing_err", error, 1);
    chk("framing_busy", busy, 0);
    chk("framing_cpu", cpu_rst_n, 0);
    send_byte(8'h33, 1'b1);
    chk("framing_writes", exp_q.size(), 0);
    chk("framing_ignored", {busy, error}, 2'b01);

    // Reset mid-frame after the second data byte
    frame3(7'h10, 8'h11, 8'h22, 8'h33, 8'h13, 1'b1);
    exp_q.push_back({7'h10, 8'h11});
    exp_q.push_back({7'h11, 8'h22});
    send_byte(8'hA5, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    chk("pre_reset_writes", exp_q.size(), 0);
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    idle(4);
    rst_n = 1'b1;
    idle(4);
    frame3(7'h10, 8'h11, 8'h22, 8'h33, 8'h13, 1'b1);

    idle(10);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
